// File: rtl/axi_10g_ethernet_0_arp_resolver.sv
// ARP resolver: IPv4 -> MAC cache with ARP request generation, retry and timeout.
module axi_10g_ethernet_0_arp_resolver #(
  parameter logic [47:0] BOARD_MAC      = 48'h02_00_c0_a8_0a_0a,
  parameter logic [31:0] BOARD_IP       = {8'd192, 8'd168, 8'd2, 8'd20},
  parameter int unsigned CACHE_DEPTH    = 16,
  parameter int unsigned TIMEOUT_CYCLES = 156250,
  parameter int unsigned MAX_RETRIES    = 3
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        lookup_valid,
  input  logic [31:0] lookup_ip,
  output logic        lookup_ready,
  output logic        resp_valid,
  output logic        resp_hit,
  output logic [47:0] resp_mac,
  input  logic        arp_rx_valid,
  input  logic [31:0] arp_rx_ip,
  input  logic [47:0] arp_rx_mac,
  input  logic        cache_flush,
  output logic [63:0] tx_axis_tdata,
  output logic [7:0]  tx_axis_tkeep,
  output logic        tx_axis_tvalid,
  output logic        tx_axis_tlast,
  input  logic        tx_axis_tready
);

  localparam int unsigned PW = (CACHE_DEPTH > 1) ? $clog2(CACHE_DEPTH) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
  localparam int unsigned RW = 4;

  typedef enum logic [2:0] {ST_IDLE, ST_LOOKUP, ST_SEND, ST_WAIT, ST_RESP} state_t;

  state_t          state_q;
  logic [31:0]     pend_ip_q;
  logic            res_hit_q;
  logic [47:0]     res_mac_q;
  logic [RW-1:0]   retries_q;
  logic [TW-1:0]   timer_q;
  logic [2:0]      beat_q;
  logic            lookup_ready_q, resp_valid_q, resp_hit_q;
  logic [47:0]     resp_mac_q;
  logic [63:0]     tdata_q;
  logic [7:0]      tkeep_q;
  logic            tvalid_q, tlast_q;

  logic [CACHE_DEPTH-1:0] valid_q;
  logic [31:0]            ip_q  [CACHE_DEPTH];
  logic [47:0]            mac_q [CACHE_DEPTH];
  logic [PW-1:0]          wr_ptr_q;

  logic            lk_hit, rx_hit, learn, rx_for_pend;
  logic [47:0]     lk_mac;
  logic [PW-1:0]   rx_idx, learn_idx;
  logic [479:0]    frame_be;
  logic [511:0]    frame_le;
  logic [2:0]      nb;

  assign lookup_ready   = lookup_ready_q;
  assign resp_valid     = resp_valid_q;
  assign resp_hit       = resp_hit_q;
  assign resp_mac       = resp_mac_q;
  assign tx_axis_tdata  = tdata_q;
  assign tx_axis_tkeep  = tkeep_q;
  assign tx_axis_tvalid = tvalid_q;
  assign tx_axis_tlast  = tlast_q;

  // Broadcast ARP request frame, wire byte order, 60 bytes including zero pad.
  assign frame_be = {48'hffff_ffff_ffff, BOARD_MAC, 16'h0806, 16'h0001, 16'h0800,
                     8'h06, 8'h04, 16'h0001, BOARD_MAC, BOARD_IP, 48'h0,
                     pend_ip_q, 144'h0};

  // Re-pack so wire byte k sits at bits [8k+7:8k]; bytes 60..63 stay zero.
  always_comb begin
    frame_le = '0;
    for (int i = 0; i < 60; i++) begin
      frame_le[8*i +: 8] = frame_be[479-8*i -: 8];
    end
  end

  assign nb          = beat_q + 3'd1;
  assign rx_for_pend = arp_rx_valid && (arp_rx_ip == pend_ip_q);
  assign learn       = arp_rx_valid && (arp_rx_ip != 32'h0) && !cache_flush;
  assign learn_idx   = rx_hit ? rx_idx : wr_ptr_q;

  // Parallel cache search for the pending lookup and for the learn address.
  always_comb begin
    lk_hit = 1'b0;
    lk_mac = '0;
    rx_hit = 1'b0;
    rx_idx = '0;
    for (int i = 0; i < CACHE_DEPTH; i++) begin
      if (valid_q[i] && (ip_q[i] == pend_ip_q)) begin
        lk_hit = 1'b1;
        lk_mac = mac_q[i];
      end
      if (valid_q[i] && (ip_q[i] == arp_rx_ip)) begin
        rx_hit = 1'b1;
        rx_idx = PW'(i);
      end
    end
  end

  // Cache valid bits and replacement pointer; flush wins over a learn.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      valid_q  <= '0;
      wr_ptr_q <= '0;
    end else if (cache_flush) begin
      valid_q  <= '0;
      wr_ptr_q <= '0;
    end else if (learn) begin
      valid_q[learn_idx] <= 1'b1;
      if (!rx_hit) begin
        wr_ptr_q <= (wr_ptr_q == PW'(CACHE_DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
      end
    end
  end

  // Cache payload storage; qualified by the valid bits so no reset needed.
  always_ff @(posedge aclk) begin
    if (learn) begin
      ip_q[learn_idx]  <= arp_rx_ip;
      mac_q[learn_idx] <= arp_rx_mac;
    end
  end

  // Resolver FSM with registered handshake, response and stream outputs.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q        <= ST_IDLE;
      pend_ip_q      <= '0;
      res_hit_q      <= 1'b0;
      res_mac_q      <= '0;
      retries_q      <= '0;
      timer_q        <= '0;
      beat_q         <= '0;
      lookup_ready_q <= 1'b0;
      resp_valid_q   <= 1'b0;
      resp_hit_q     <= 1'b0;
      resp_mac_q     <= '0;
      tdata_q        <= '0;
      tkeep_q        <= '0;
      tvalid_q       <= 1'b0;
      tlast_q        <= 1'b0;
    end else begin
      resp_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (lookup_valid && lookup_ready_q) begin
            pend_ip_q      <= lookup_ip;
            lookup_ready_q <= 1'b0;
            state_q        <= ST_LOOKUP;
          end else begin
            lookup_ready_q <= 1'b1;
          end
        end
        ST_LOOKUP: begin
          if (rx_for_pend) begin
            res_hit_q <= 1'b1;
            res_mac_q <= arp_rx_mac;
            state_q   <= ST_RESP;
          end else if (lk_hit) begin
            res_hit_q <= 1'b1;
            res_mac_q <= lk_mac;
            state_q   <= ST_RESP;
          end else begin
            retries_q <= '0;
            tvalid_q  <= 1'b1;
            tdata_q   <= frame_le[63:0];
            tkeep_q   <= 8'hFF;
            tlast_q   <= 1'b0;
            beat_q    <= '0;
            state_q   <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (tvalid_q && tx_axis_tready) begin
            if (beat_q == 3'd7) begin
              tvalid_q <= 1'b0;
              tlast_q  <= 1'b0;
              tkeep_q  <= '0;
              tdata_q  <= '0;
              timer_q  <= '0;
              state_q  <= ST_WAIT;
            end else begin
              beat_q  <= nb;
              tdata_q <= frame_le[{nb, 6'd0} +: 64];
              tkeep_q <= (nb == 3'd7) ? 8'h0F : 8'hFF;
              tlast_q <= (nb == 3'd7);
            end
          end
        end
        ST_WAIT: begin
          if (rx_for_pend) begin
            res_hit_q <= 1'b1;
            res_mac_q <= arp_rx_mac;
            state_q   <= ST_RESP;
          end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
            if (retries_q < RW'(MAX_RETRIES)) begin
              retries_q <= retries_q + RW'(1);
              tvalid_q  <= 1'b1;
              tdata_q   <= frame_le[63:0];
              tkeep_q   <= 8'hFF;
              tlast_q   <= 1'b0;
              beat_q    <= '0;
              state_q   <= ST_SEND;
            end else begin
              res_hit_q <= 1'b0;
              res_mac_q <= '0;
              state_q   <= ST_RESP;
            end
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        ST_RESP: begin
          resp_valid_q   <= 1'b1;
          resp_hit_q     <= res_hit_q;
          resp_mac_q     <= res_hit_q ? res_mac_q : 48'h0;
          lookup_ready_q <= 1'b1;
          state_q        <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_10g_ethernet_0_arp_resolver.sv
// Bench for the ARP resolver: directed scenarios plus randomized learn/lookup traffic.
module tb_axi_10g_ethernet_0_arp_resolver;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned TO    = 20;
  localparam int unsigned RETRY = 2;
  localparam logic [47:0] MAC   = 48'h02_00_c0_a8_0a_0a;
  localparam logic [31:0] MYIP  = {8'd192, 8'd168, 8'd2, 8'd20};

  logic        aclk = 1'b0;
  logic        aresetn = 1'b1;
  logic        lookup_valid = 1'b0;
  logic [31:0] lookup_ip = '0;
  logic        lookup_ready;
  logic        resp_valid, resp_hit;
  logic [47:0] resp_mac;
  logic        arp_rx_valid = 1'b0;
  logic [31:0] arp_rx_ip = '0;
  logic [47:0] arp_rx_mac = '0;
  logic        cache_flush = 1'b0;
  logic [63:0] tx_axis_tdata;
  logic [7:0]  tx_axis_tkeep;
  logic        tx_axis_tvalid, tx_axis_tlast;
  logic        tx_axis_tready = 1'b1;

  int checks = 0;
  int failures = 0;

  axi_10g_ethernet_0_arp_resolver #(
    .BOARD_MAC(MAC), .BOARD_IP(MYIP), .CACHE_DEPTH(DEPTH),
    .TIMEOUT_CYCLES(TO), .MAX_RETRIES(RETRY)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .lookup_valid(lookup_valid), .lookup_ip(lookup_ip), .lookup_ready(lookup_ready),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_mac(resp_mac),
    .arp_rx_valid(arp_rx_valid), .arp_rx_ip(arp_rx_ip), .arp_rx_mac(arp_rx_mac),
    .cache_flush(cache_flush),
    .tx_axis_tdata(tx_axis_tdata), .tx_axis_tkeep(tx_axis_tkeep),
    .tx_axis_tvalid(tx_axis_tvalid), .tx_axis_tlast(tx_axis_tlast),
    .tx_axis_tready(tx_axis_tready)
  );

  always #5 aclk = ~aclk;

  // Reference cache: IP->MAC map plus the slot each IP occupies in replacement order.
  logic [47:0] m_cache [logic [31:0]];
  logic [31:0] m_slot [DEPTH];
  bit          m_used [DEPTH];
  int          m_ptr = 0;

  task automatic m_learn(input logic [31:0] ip, input logic [47:0] mac);
    if (ip == 32'h0) return;
    if (m_cache.exists(ip)) begin
      m_cache[ip] = mac;
    end else begin
      if (m_used[m_ptr]) m_cache.delete(m_slot[m_ptr]);
      m_cache[ip]    = mac;
      m_slot[m_ptr]  = ip;
      m_used[m_ptr]  = 1'b1;
      m_ptr          = (m_ptr + 1) % DEPTH;
    end
  endtask

  task automatic m_flush;
    m_cache.delete();
    for (int i = 0; i < DEPTH; i++) m_used[i] = 1'b0;
    m_ptr = 0;
  endtask

  // Expected 64-bit beat built from the ARP request byte list.
  function automatic logic [63:0] exp_beat(input logic [31:0] ip, input int b);
    logic [7:0]  q[$];
    logic [63:0] r;
    logic [15:0] hdr [4];
    hdr[0] = 16'h0806; hdr[1] = 16'h0001; hdr[2] = 16'h0800; hdr[3] = 16'h0604;
    for (int i = 0; i < 6; i++) q.push_back(8'hff);
    for (int i = 0; i < 6; i++) q.push_back(MAC[47-8*i -: 8]);
    for (int i = 0; i < 4; i++) begin q.push_back(hdr[i][15:8]); q.push_back(hdr[i][7:0]); end
    q.push_back(8'h00); q.push_back(8'h01);
    for (int i = 0; i < 6; i++) q.push_back(MAC[47-8*i -: 8]);
    for (int i = 0; i < 4; i++) q.push_back(MYIP[31-8*i -: 8]);
    for (int i = 0; i < 6; i++) q.push_back(8'h00);
    for (int i = 0; i < 4; i++) q.push_back(ip[31-8*i -: 8]);
    while (q.size() < 64) q.push_back(8'h00);
    for (int n = 0; n < 8; n++) r[8*n +: 8] = q[8*b + n];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge aclk);
    #1;
  endtask

  task automatic learn(input logic [31:0] ip, input logic [47:0] mac);
    arp_rx_valid = 1'b1; arp_rx_ip = ip; arp_rx_mac = mac;
    m_learn(ip, mac);
    tick;
    arp_rx_valid = 1'b0;
  endtask

  // One lookup transaction; checks every beat, stall stability and retry spacing.
  task automatic run_lookup(input logic [31:0] ip, input int reply_frame, input int reply_delay,
                            input logic [47:0] reply_mac, output int lat, output int beats,
                            output int tail, output logic hit, output logic [47:0] mac);
    int cnt, since, bi, guard;
    logic replied, hold, gap_pending;
    logic [63:0] hd;
    guard = 0;
    while (!lookup_ready && guard < 100) begin tick; guard++; end
    chk("ready_before_lookup", 64'(lookup_ready), 64'(1));
    lookup_valid = 1'b1; lookup_ip = ip;
    tick;
    lookup_valid = 1'b0;
    chk("ready_low_after_accept", 64'(lookup_ready), 64'(0));
    cnt = 0; since = 0; bi = 0; replied = 1'b0; hold = 1'b0; gap_pending = 1'b0; hd = '0;
    while (!resp_valid && cnt < 2000) begin
      arp_rx_valid   = 1'b0;
      tx_axis_tready = 1'($urandom_range(0, 1));
      if (!replied && reply_frame >= 0 && bi == 8*reply_frame && since == reply_delay) begin
        arp_rx_valid = 1'b1; arp_rx_ip = ip; arp_rx_mac = reply_mac;
        m_learn(ip, reply_mac);
        replied = 1'b1;
      end
      if (hold) begin
        chk("stall_tvalid", 64'(tx_axis_tvalid), 64'(1));
        chk("stall_tdata", tx_axis_tdata, hd);
      end
      if (gap_pending && tx_axis_tvalid) begin
        chk("retry_gap", 64'(since), 64'(TO + 1));
        gap_pending = 1'b0;
      end
      hold = 1'b0;
      if (tx_axis_tvalid) begin
        if (tx_axis_tready) begin
          chk("beat_data", tx_axis_tdata, exp_beat(ip, bi % 8));
          chk("beat_keep", 64'(tx_axis_tkeep), (bi % 8 == 7) ? 64'h0F : 64'hFF);
          chk("beat_last", 64'(tx_axis_tlast), 64'(bi % 8 == 7));
          bi++;
          if (bi % 8 == 0) begin since = 0; gap_pending = 1'b1; end
        end else begin
          hold = 1'b1; hd = tx_axis_tdata;
        end
      end
      tick; cnt++; since++;
    end
    chk("resp_seen", 64'(resp_valid), 64'(1));
    lat = cnt; beats = bi; tail = since; hit = resp_hit; mac = resp_mac;
    arp_rx_valid = 1'b0; tx_axis_tready = 1'b1;
    tick;
    chk("resp_single_pulse", 64'(resp_valid), 64'(0));
    chk("tvalid_idle", 64'(tx_axis_tvalid), 64'(0));
  endtask

  // Lookup with expectations taken from the reference cache.
  task automatic do_lookup(input string tag, input logic [31:0] ip, input int rf,
                           input int rd, input logic [47:0] rmac);
    logic        e_hit, hit;
    logic [47:0] e_mac, mac;
    int          e_beats, e_lat, e_tail, lat, beats, tail;
    e_lat = -1; e_tail = -1;
    if (m_cache.exists(ip)) begin
      e_hit = 1'b1; e_mac = m_cache[ip]; e_beats = 0; e_lat = 2;
    end else if (rf == 0 && rd == 0) begin
      e_hit = 1'b1; e_mac = rmac; e_beats = 0; e_lat = 2;
    end else if (rf >= 1 && rf <= RETRY + 1 && rd >= 1 && rd <= TO) begin
      e_hit = 1'b1; e_mac = rmac; e_beats = 8 * rf;
    end else begin
      e_hit = 1'b0; e_mac = 48'h0; e_beats = 8 * (RETRY + 1); e_tail = TO + 2;
    end
    run_lookup(ip, rf, rd, rmac, lat, beats, tail, hit, mac);
    chk({tag, "_hit"}, 64'(hit), 64'(e_hit));
    chk({tag, "_mac"}, 64'(mac), 64'(e_mac));
    chk({tag, "_beats"}, 64'(beats), 64'(e_beats));
    if (e_lat >= 0) chk({tag, "_latency"}, 64'(lat), 64'(e_lat));
    if (e_tail >= 0) chk({tag, "_timeout_tail"}, 64'(tail), 64'(e_tail));
  endtask

  initial begin
    logic [31:0] ips [8];
    logic [31:0] ip;
    int bi, g;

    // Reset values while aresetn is low, then ready after release.
    #2 aresetn = 1'b0;
    #30;
    chk("rst_ready", 64'(lookup_ready), 64'(0));
    chk("rst_resp_valid", 64'(resp_valid), 64'(0));
    chk("rst_resp_hit", 64'(resp_hit), 64'(0));
    chk("rst_resp_mac", 64'(resp_mac), 64'(0));
    chk("rst_tvalid", 64'(tx_axis_tvalid), 64'(0));
    chk("rst_tlast", 64'(tx_axis_tlast), 64'(0));
    chk("rst_tkeep", 64'(tx_axis_tkeep), 64'(0));
    chk("rst_tdata", tx_axis_tdata, 64'(0));
    aresetn = 1'b1;
    tick;
    chk("ready_after_reset", 64'(lookup_ready), 64'(1));

    // Learned entry resolves from the cache with no frame.
    learn({8'd10, 8'd0, 8'd0, 8'd5}, 48'hA1_A2_A3_A4_A5_A6);
    do_lookup("cached", {8'd10, 8'd0, 8'd0, 8'd5}, -1, 0, 48'h0);

    // Miss with reply after the first frame.
    do_lookup("miss_reply", {8'd10, 8'd0, 8'd0, 8'd9}, 1, 5, 48'hB1_B2_B3_B4_B5_B6);

    // No reply: all attempts sent, then failure.
    do_lookup("timeout", {8'd10, 8'd0, 8'd0, 8'd77}, -1, 0, 48'h0);

    // Reply coincides with the final timeout expiry: hit wins.
    do_lookup("reply_at_expiry", {8'd10, 8'd0, 8'd0, 8'd78}, RETRY + 1, TO, 48'hC1_C2_C3_C4_C5_C6);

    // Reply arriving during the lookup cycle bypasses the cache.
    do_lookup("lookup_bypass", {8'd10, 8'd0, 8'd0, 8'd79}, 0, 0, 48'hD1_D2_D3_D4_D5_D6);

    // Learn DEPTH+1 distinct IPs so the oldest is evicted.
    cache_flush = 1'b1; m_flush; tick; cache_flush = 1'b0;
    for (int i = 0; i < 8; i++) ips[i] = {8'd172, 8'(i + 1), 16'($urandom)};
    for (int i = 0; i <= DEPTH; i++) learn(ips[i], {16'($urandom), 32'($urandom)});
    do_lookup("evicted_first", ips[0], 1, 3, 48'hE1_E2_E3_E4_E5_E6);
    do_lookup("newest_hit", ips[DEPTH], -1, 0, 48'h0);
    learn(ips[DEPTH], 48'hF1_F2_F3_F4_F5_F6);
    do_lookup("relearn_mac", ips[DEPTH], -1, 0, 48'h0);
    learn(ips[5], {16'($urandom), 32'($urandom)});
    for (int i = 0; i < 6; i++) do_lookup("after_relearn", ips[i], 1, 2, {16'($urandom), 32'($urandom)});

    // Randomized learn/lookup traffic against the reference cache.
    for (int n = 0; n < 14; n++) begin
      ip = ips[$urandom_range(0, 7)];
      if ($urandom_range(0, 1) == 0) learn(ip, {16'($urandom), 32'($urandom)});
      else do_lookup("random", ip, 1, int'($urandom_range(1, TO)), {16'($urandom), 32'($urandom)});
    end

    // Flush in the same cycle as a learn: both previous and new IP miss.
    learn(32'h0A00_0101, 48'h11_22_33_44_55_66);
    arp_rx_valid = 1'b1; arp_rx_ip = 32'h0A00_0102; arp_rx_mac = 48'h66_55_44_33_22_11;
    cache_flush = 1'b1; m_flush;
    tick;
    arp_rx_valid = 1'b0; cache_flush = 1'b0;
    do_lookup("flushed_old", 32'h0A00_0101, 1, 4, 48'h12_12_12_12_12_12);
    do_lookup("flush_dropped_learn", 32'h0A00_0102, 1, 4, 48'h34_34_34_34_34_34);

    // IP 0 is never learned.
    learn(32'h0, 48'h99_99_99_99_99_99);
    do_lookup("zero_ip_not_learned", 32'h0, 1, 2, 48'h77_77_77_77_77_77);

    // Reset in the middle of a frame.
    learn(32'h0A00_0200, 48'hAB_AB_AB_AB_AB_AB);
    ip = 32'h0A00_0203;
    g = 0;
    while (!lookup_ready && g < 100) begin tick; g++; end
    lookup_valid = 1'b1; lookup_ip = ip; tick; lookup_valid = 1'b0;
    tx_axis_tready = 1'b1; bi = 0; g = 0;
    while (!(tx_axis_tvalid && bi == 3) && g < 100) begin
      if (tx_axis_tvalid) bi++;
      tick; g++;
    end
    chk("abort_beat3_reached", 64'(tx_axis_tvalid && bi == 3), 64'(1));
    chk("abort_beat3_data", tx_axis_tdata, exp_beat(ip, 3));
    #2 aresetn = 1'b0;
    #1;
    chk("abort_tvalid", 64'(tx_axis_tvalid), 64'(0));
    chk("abort_tlast", 64'(tx_axis_tlast), 64'(0));
    m_flush;
    repeat (3) begin
      tick;
      chk("abort_no_resp", 64'(resp_valid), 64'(0));
    end
    #3 aresetn = 1'b1;
    tick;
    chk("abort_ready", 64'(lookup_ready), 64'(1));
    chk("abort_no_resp_after", 64'(resp_valid), 64'(0));
    do_lookup("cache_empty_after_reset", 32'h0A00_0200, 1, 3, 48'hCD_CD_CD_CD_CD_CD);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
